// File: rtl/irq_trap_ctrl_if.sv
// Interrupt/trap sequencer bus: core and CSR-file signals seen by irq_trap_ctrl.
// master = core/CSR side, slave = the trap sequencer.
interface irq_trap_ctrl_if;
  logic        irq_sw;
  logic        irq_tmr;
  logic        irq_ext;
  logic [2:0]  mie_en;
  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic [31:0] mtvec_base;
  logic [31:0] mepc_in;
  logic [31:0] pc_m;
  logic        valid_m;
  logic        mret_m;
  logic        stall_m;
  logic [2:0]  pend;
  logic        busy;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        csr_we;
  logic [31:0] mepc_out;
  logic [31:0] mcause_out;
  logic        mstatus_we;
  logic        mie_out;
  logic        mpie_out;

  modport master (
    output irq_sw, irq_tmr, irq_ext, mie_en, mstatus_mie, mstatus_mpie, mtvec_base, mepc_in,
           pc_m, valid_m, mret_m, stall_m,
    input  pend, busy, flush, redirect, redirect_pc, csr_we, mepc_out, mcause_out,
           mstatus_we, mie_out, mpie_out
  );

  modport slave (
    input  irq_sw, irq_tmr, irq_ext, mie_en, mstatus_mie, mstatus_mpie, mtvec_base, mepc_in,
           pc_m, valid_m, mret_m, stall_m,
    output pend, busy, flush, redirect, redirect_pc, csr_we, mepc_out, mcause_out,
           mstatus_we, mie_out, mpie_out
  );
endinterface

// File: rtl/irq_trap_ctrl.sv
// Machine-mode interrupt/trap sequencer: samples interrupts, sequences trap entry
// (flush, drain, CSR commit, redirect) and mret return. All outputs are registered.
module irq_trap_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter bit          VECTORED     = 1'b0
) (
  input logic            clk,
  input logic            rst,
  irq_trap_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StDrain, StEnter, StReturn} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [3:0]  code_q;
  logic        mpie_q;

  logic [2:0]  hit;
  logic        take;
  logic [3:0]  code;
  logic [3:0]  ent_code;
  logic        ent_mpie;
  logic [31:0] ent_pc;
  logic        unused_lsb;

  assign hit  = bus.pend & bus.mie_en;
  assign take = bus.mstatus_mie & (|hit) & bus.valid_m & ~bus.stall_m;

  // MEI > MSI > MTI
  always_comb begin
    code = 4'd7;
    if (hit[2]) begin
      code = 4'd11;
    end else if (hit[0]) begin
      code = 4'd3;
    end
  end

  // Enter happens either straight from IDLE (no drain) or at the end of DRAIN.
  assign ent_code = (state_q == StDrain) ? code_q : code;
  assign ent_mpie = (state_q == StDrain) ? mpie_q : bus.mstatus_mie;
  assign ent_pc   = {bus.mtvec_base[31:2], 2'b00} +
                    (VECTORED ? {26'd0, ent_code, 2'b00} : 32'd0);

  assign unused_lsb = ^{bus.mtvec_base[1:0], bus.mepc_in[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      code_q          <= '0;
      mpie_q          <= 1'b0;
      bus.pend        <= '0;
      bus.busy        <= 1'b0;
      bus.flush       <= 1'b0;
      bus.redirect    <= 1'b0;
      bus.redirect_pc <= '0;
      bus.csr_we      <= 1'b0;
      bus.mepc_out    <= '0;
      bus.mcause_out  <= '0;
      bus.mstatus_we  <= 1'b0;
      bus.mie_out     <= 1'b0;
      bus.mpie_out    <= 1'b0;
    end else begin
      bus.pend       <= {bus.irq_ext, bus.irq_tmr, bus.irq_sw};
      bus.redirect   <= 1'b0;
      bus.csr_we     <= 1'b0;
      bus.mstatus_we <= 1'b0;
      case (state_q)
        StIdle: begin
          if (take) begin
            bus.mepc_out   <= bus.pc_m;
            bus.mcause_out <= {1'b1, 27'd0, code};
            code_q         <= code;
            mpie_q         <= bus.mstatus_mie;
            bus.busy       <= 1'b1;
            bus.flush      <= 1'b1;
            if (DRAIN_CYCLES > 0) begin
              state_q <= StDrain;
              cnt_q   <= 4'(DRAIN_CYCLES - 1);
            end else begin
              state_q         <= StEnter;
              bus.redirect    <= 1'b1;
              bus.redirect_pc <= ent_pc;
              bus.csr_we      <= 1'b1;
              bus.mstatus_we  <= 1'b1;
              bus.mie_out     <= 1'b0;
              bus.mpie_out    <= ent_mpie;
            end
          end else if (bus.valid_m && bus.mret_m && !bus.stall_m) begin
            state_q         <= StReturn;
            bus.busy        <= 1'b1;
            bus.flush       <= 1'b1;
            bus.redirect    <= 1'b1;
            bus.redirect_pc <= {bus.mepc_in[31:2], 2'b00};
            bus.mstatus_we  <= 1'b1;
            bus.mie_out     <= bus.mstatus_mpie;
            bus.mpie_out    <= 1'b1;
          end
        end
        StDrain: begin
          if (cnt_q == 4'd0) begin
            state_q         <= StEnter;
            bus.redirect    <= 1'b1;
            bus.redirect_pc <= ent_pc;
            bus.csr_we      <= 1'b1;
            bus.mstatus_we  <= 1'b1;
            bus.mie_out     <= 1'b0;
            bus.mpie_out    <= ent_mpie;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StEnter, StReturn: begin
          state_q   <= StIdle;
          bus.busy  <= 1'b0;
          bus.flush <= 1'b0;
        end
        default: begin
          state_q   <= StIdle;
          bus.busy  <= 1'b0;
          bus.flush <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_trap_ctrl.sv
// Bench for irq_trap_ctrl: directed plan steps plus random traffic against a cycle-count
// model, on two instances (drain 2 / direct, drain 0 / vectored) sharing one input set.
module tb_irq_trap_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        irq_sw, irq_tmr, irq_ext, mstatus_mie, mstatus_mpie;
  logic        valid_m, mret_m, stall_m;
  logic [2:0]  mie_en;
  logic [31:0] mtvec_base, mepc_in, pc_m;

  int checks   = 0;
  int failures = 0;

  irq_trap_ctrl_if ifa ();
  irq_trap_ctrl_if ifb ();

  assign ifa.irq_sw = irq_sw;             assign ifb.irq_sw = irq_sw;
  assign ifa.irq_tmr = irq_tmr;           assign ifb.irq_tmr = irq_tmr;
  assign ifa.irq_ext = irq_ext;           assign ifb.irq_ext = irq_ext;
  assign ifa.mie_en = mie_en;             assign ifb.mie_en = mie_en;
  assign ifa.mstatus_mie = mstatus_mie;   assign ifb.mstatus_mie = mstatus_mie;
  assign ifa.mstatus_mpie = mstatus_mpie; assign ifb.mstatus_mpie = mstatus_mpie;
  assign ifa.mtvec_base = mtvec_base;     assign ifb.mtvec_base = mtvec_base;
  assign ifa.mepc_in = mepc_in;           assign ifb.mepc_in = mepc_in;
  assign ifa.pc_m = pc_m;                 assign ifb.pc_m = pc_m;
  assign ifa.valid_m = valid_m;           assign ifb.valid_m = valid_m;
  assign ifa.mret_m = mret_m;             assign ifb.mret_m = mret_m;
  assign ifa.stall_m = stall_m;           assign ifb.stall_m = stall_m;

  irq_trap_ctrl #(.DRAIN_CYCLES(2), .VECTORED(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  irq_trap_ctrl #(.DRAIN_CYCLES(0), .VECTORED(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  // rem = cycles of busy still ahead (0 = idle); the last busy cycle is the redirect cycle.
  typedef struct packed {
    int          rem;
    logic        trap;
    logic [2:0]  pend;
    logic [31:0] mepc;
    logic [31:0] cause;
    logic [31:0] rpc;
    logic        mie_o;
    logic        mpie_o;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t step(input mdl_t m, input int d, input bit v);
    mdl_t n;
    logic [2:0] en;
    int code;
    n = m;
    if (rst) return '0;
    n.pend = {irq_ext, irq_tmr, irq_sw};
    en = m.pend & mie_en;
    if (m.rem > 0) begin
      n.rem = m.rem - 1;
    end else if (mstatus_mie && en != 3'b000 && valid_m && !stall_m) begin
      code = en[2] ? 11 : (en[0] ? 3 : 7);
      n.rem    = d + 1;
      n.trap   = 1'b1;
      n.mepc   = pc_m;
      n.cause  = 32'h8000_0000 | 32'(code);
      n.rpc    = (mtvec_base & 32'hFFFF_FFFC) + (v ? 32'(code) * 32'd4 : 32'd0);
      n.mie_o  = 1'b0;
      n.mpie_o = mstatus_mie;
    end else if (valid_m && mret_m && !stall_m) begin
      n.rem    = 1;
      n.trap   = 1'b0;
      n.rpc    = mepc_in & 32'hFFFF_FFFC;
      n.mie_o  = mstatus_mpie;
      n.mpie_o = 1'b1;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_dut(input string p, input mdl_t m, input logic [2:0] pend,
                         input logic busy, input logic flush, input logic redirect,
                         input logic [31:0] rpc, input logic csr_we, input logic [31:0] mepc,
                         input logic [31:0] cause, input logic mstatus_we,
                         input logic mie_o, input logic mpie_o);
    chk({p, ".pend"}, 32'(pend), 32'(m.pend));
    chk({p, ".busy"}, 32'(busy), 32'(m.rem > 0));
    chk({p, ".flush"}, 32'(flush), 32'(m.rem > 0));
    chk({p, ".redirect"}, 32'(redirect), 32'(m.rem == 1));
    chk({p, ".mstatus_we"}, 32'(mstatus_we), 32'(m.rem == 1));
    chk({p, ".csr_we"}, 32'(csr_we), 32'(m.rem == 1 && m.trap));
    chk({p, ".mepc_out"}, mepc, m.mepc);
    chk({p, ".mcause_out"}, cause, m.cause);
    if (m.rem == 1) begin
      chk({p, ".redirect_pc"}, rpc, m.rpc);
      chk({p, ".mie_out"}, 32'(mie_o), 32'(m.mie_o));
      chk({p, ".mpie_out"}, 32'(mpie_o), 32'(m.mpie_o));
    end
  endtask

  task automatic cycle();
    ma = step(ma, 2, 1'b0);
    mb = step(mb, 0, 1'b1);
    @(posedge clk);
    #1;
    chk_dut("a", ma, ifa.pend, ifa.busy, ifa.flush, ifa.redirect, ifa.redirect_pc, ifa.csr_we,
            ifa.mepc_out, ifa.mcause_out, ifa.mstatus_we, ifa.mie_out, ifa.mpie_out);
    chk_dut("b", mb, ifb.pend, ifb.busy, ifb.flush, ifb.redirect, ifb.redirect_pc, ifb.csr_we,
            ifb.mepc_out, ifb.mcause_out, ifb.mstatus_we, ifb.mie_out, ifb.mpie_out);
  endtask

  task automatic settle();
    irq_sw = 1'b0; irq_tmr = 1'b0; irq_ext = 1'b0; mret_m = 1'b0;
    for (int i = 0; i < 8; i++) cycle();
  endtask

  task automatic chk_zero(input string p, input logic [31:0] rpc, input logic mie_o,
                          input logic mpie_o);
    chk({p, ".rst_redirect_pc"}, rpc, 32'd0);
    chk({p, ".rst_mie_out"}, 32'(mie_o), 32'd0);
    chk({p, ".rst_mpie_out"}, 32'(mpie_o), 32'd0);
  endtask

  initial begin
    int nflush;
    ma = '0; mb = '0;
    rst = 1'b1;
    irq_sw = 1'b0; irq_tmr = 1'b0; irq_ext = 1'b0;
    mie_en = 3'b100; mstatus_mie = 1'b1; mstatus_mpie = 1'b1;
    mtvec_base = 32'h20; mepc_in = 32'h44; pc_m = 32'h40;
    valid_m = 1'b1; mret_m = 1'b0; stall_m = 1'b0;

    cycle(); cycle();
    chk_zero("a", ifa.redirect_pc, ifa.mie_out, ifa.mpie_out);
    chk_zero("b", ifb.redirect_pc, ifb.mie_out, ifb.mpie_out);
    rst = 1'b0;
    cycle();

    // External interrupt, direct mode, two drain cycles.
    irq_ext = 1'b1;
    nflush = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      nflush += int'(ifa.flush);
      if (ifa.redirect) break;
    end
    chk("p1.redirect", 32'(ifa.redirect), 32'd1);
    chk("p1.flush_cycles", 32'(nflush), 32'd3);
    chk("p1.redirect_pc", ifa.redirect_pc, 32'h20);
    chk("p1.mepc_out", ifa.mepc_out, 32'h40);
    chk("p1.mcause_out", ifa.mcause_out, 32'h8000_000B);
    chk("p1.mie_out", 32'(ifa.mie_out), 32'd0);
    chk("p1.mpie_out", 32'(ifa.mpie_out), 32'd1);
    settle();

    // Timer + software pending, vectored: software wins.
    mie_en = 3'b111; mtvec_base = 32'h100;
    irq_tmr = 1'b1; irq_sw = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (ifb.redirect) break;
    end
    chk("p2.redirect", 32'(ifb.redirect), 32'd1);
    chk("p2.mcause_out", ifb.mcause_out, 32'h8000_0003);
    chk("p2.redirect_pc", ifb.redirect_pc, 32'h10C);
    settle();

    // mret.
    mepc_in = 32'h44; mstatus_mpie = 1'b1; mret_m = 1'b1;
    cycle();
    mret_m = 1'b0;
    chk("p3.redirect", 32'(ifa.redirect), 32'd1);
    chk("p3.redirect_pc", ifa.redirect_pc, 32'h44);
    chk("p3.mie_out", 32'(ifa.mie_out), 32'd1);
    chk("p3.mpie_out", 32'(ifa.mpie_out), 32'd1);
    chk("p3.csr_we", 32'(ifa.csr_we), 32'd0);
    settle();

    // mret collides with a pending interrupt: the trap wins.
    mie_en = 3'b100; pc_m = 32'h80; irq_ext = 1'b1; stall_m = 1'b1;
    cycle();
    stall_m = 1'b0; mret_m = 1'b1;
    cycle();
    mret_m = 1'b0;
    chk("p4.busy", 32'(ifa.busy), 32'd1);
    chk("p4.mepc_out", ifa.mepc_out, 32'h80);
    chk("p4.redirect_early", 32'(ifa.redirect), 32'd0);
    for (int i = 0; i < 8; i++) begin
      if (ifa.redirect) break;
      cycle();
    end
    chk("p4.csr_we", 32'(ifa.csr_we), 32'd1);
    settle();

    // Gating by mstatus.MIE, stall and valid.
    for (int g = 0; g < 3; g++) begin
      mstatus_mie = (g != 0); stall_m = (g == 1); valid_m = (g != 2);
      irq_ext = 1'b1;
      for (int i = 0; i < 3; i++) begin
        cycle();
        chk("p5.gated_busy", 32'(ifa.busy), 32'd0);
      end
      mstatus_mie = 1'b1; stall_m = 1'b0; valid_m = 1'b1;
      cycle();
      chk("p5.ungated_busy", 32'(ifa.busy), 32'd1);
      settle();
    end

    // Reset during the first drain cycle.
    irq_ext = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (ifa.busy) break;
    end
    chk("p6.in_drain", 32'(ifa.busy), 32'd1);
    rst = 1'b1; irq_ext = 1'b0;
    cycle();
    rst = 1'b0;
    chk("p6.busy", 32'(ifa.busy), 32'd0);
    chk("p6.flush", 32'(ifa.flush), 32'd0);
    chk("p6.mepc_out", ifa.mepc_out, 32'd0);
    chk("p6.mcause_out", ifa.mcause_out, 32'd0);
    chk_zero("p6", ifa.redirect_pc, ifa.mie_out, ifa.mpie_out);
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("p6.no_redirect", 32'(ifa.redirect), 32'd0);
      chk("p6.no_csr_we", 32'(ifa.csr_we), 32'd0);
    end

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0) irq_sw = ~irq_sw;
      if ($urandom_range(0, 7) == 0) irq_tmr = ~irq_tmr;
      if ($urandom_range(0, 7) == 0) irq_ext = ~irq_ext;
      if ($urandom_range(0, 15) == 0) mie_en = 3'($urandom_range(0, 7));
      mstatus_mie  = ($urandom_range(0, 3) != 0);
      mstatus_mpie = 1'($urandom_range(0, 1));
      valid_m      = ($urandom_range(0, 4) != 0);
      stall_m      = ($urandom_range(0, 4) == 0);
      mret_m       = ($urandom_range(0, 9) == 0);
      pc_m         = $urandom;
      mepc_in      = $urandom;
      if (ma.rem == 0 && mb.rem == 0 && $urandom_range(0, 9) == 0) mtvec_base = $urandom;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
